// File: rtl/i2s_rcvr_controller.sv
// I2S receive sequencer: aligns on the left-channel WS edge, skips the one-bit MSB delay,
// shifts in channel words MSB-first and presents left/right pairs with a valid/ack handshake.
module i2s_rcvr_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  ws,
   input  logic                  ws_edge,
   input  logic                  shift_strobe,
   input  logic                  sd,
   input  logic                  sample_ack,
   input  logic                  clear_overrun,
   output logic [DATA_WIDTH-1:0] left_data,
   output logic [DATA_WIDTH-1:0] right_data,
   output logic                  sample_valid,
   output logic                  overrun,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DATA_WIDTH);

   state_t                state, state_nx;
   logic [CNT_WIDTH-1:0]  bit_cnt, bit_cnt_nx;
   logic [DATA_WIDTH-1:0] shreg, shreg_nx;
   logic [DATA_WIDTH-1:0] left_hold, left_hold_nx;
   logic                  left_have, left_have_nx;
   logic                  pair_done;
   logic [DATA_WIDTH-1:0] word_closed;

   // Left-justify the captured bits; a short frame leaves zero LSBs, an empty one yields 0.
   assign word_closed = shreg << (FULL_CNT - bit_cnt);

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_nx     = state;
      bit_cnt_nx   = bit_cnt;
      shreg_nx     = shreg;
      left_hold_nx = left_hold;
      left_have_nx = left_have;
      pair_done    = 1'b0;

      if (!enable) begin
         state_nx     = IDLE;
         bit_cnt_nx   = '0;
         left_have_nx = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ws_edge && !ws) begin
                  state_nx   = DELAY;
                  bit_cnt_nx = '0;
                  shreg_nx   = '0;
               end
            end
            DELAY, SHIFT: begin
               if (ws_edge) begin
                  if (ws) begin
                     left_hold_nx = word_closed;
                     left_have_nx = 1'b1;
                  end else begin
                     pair_done    = left_have;
                     left_have_nx = 1'b0;
                  end
                  // A strobe coinciding with the edge is the delay slot of the next word.
                  state_nx   = shift_strobe ? SHIFT : DELAY;
                  bit_cnt_nx = '0;
                  shreg_nx   = '0;
               end else if (shift_strobe) begin
                  if (state == DELAY) begin
                     state_nx   = SHIFT;
                     bit_cnt_nx = '0;
                  end else if (bit_cnt < FULL_CNT) begin
                     shreg_nx   = {shreg[DATA_WIDTH-2:0], sd};
                     bit_cnt_nx = bit_cnt + 1'b1;
                  end
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         left_hold <= '0;
         left_have <= 1'b0;
      end else begin
         state     <= state_nx;
         bit_cnt   <= bit_cnt_nx;
         shreg     <= shreg_nx;
         left_hold <= left_hold_nx;
         left_have <= left_have_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (pair_done) begin
            left_data    <= left_hold;
            right_data   <= word_closed;
            sample_valid <= 1'b1;
         end else if (sample_ack) begin
            sample_valid <= 1'b0;
         end

         // Overwriting an unacknowledged pair beats a simultaneous clear.
         if (pair_done && sample_valid && !sample_ack)
            overrun <= 1'b1;
         else if (clear_overrun)
            overrun <= 1'b0;
      end
   end

   assign busy = (state == DELAY) || (state == SHIFT);

endmodule

// File: tb/tb_i2s_rcvr_controller.sv
// Scoreboard bench for i2s_rcvr_controller: expected pairs are queued when the closing
// WS edge is driven and compared once the DUT has had its clock edge to publish them.
module tb_i2s_rcvr_controller;

   logic        clk = 1'b0;
   logic        rst, enable, ws, ws_edge, shift_strobe, sd, sample_ack, clear_overrun;
   logic [15:0] left_data, right_data;
   logic        sample_valid, overrun, busy;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      logic        ov;
   } pair_t;

   pair_t       sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   // Reference model state
   logic        active_m, left_have_m, valid_m, ov_m;
   logic [15:0] left_m, cur_m;

   i2s_rcvr_controller #(.DATA_WIDTH(16), .CNT_WIDTH(5)) dut (
      .clk(clk), .rst(rst), .enable(enable), .ws(ws), .ws_edge(ws_edge),
      .shift_strobe(shift_strobe), .sd(sd), .sample_ack(sample_ack),
      .clear_overrun(clear_overrun), .left_data(left_data), .right_data(right_data),
      .sample_valid(sample_valid), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [31:0] bits, input int n);
      logic [31:0] t;
      if (n >= 16) t = bits >> (n - 16);
      else         t = bits << (16 - n);
      return t[15:0];
   endfunction

   task automatic check_status(input string tag);
      check({tag, ".valid"}, 32'(sample_valid), 32'(valid_m));
      check({tag, ".ovr"},   32'(overrun),      32'(ov_m));
      check({tag, ".busy"},  32'(busy),         32'(active_m));
   endtask

   task automatic strobe(input logic b);
      @(negedge clk);
      shift_strobe = 1'b1;
      sd           = b;
      @(negedge clk);
      shift_strobe = 1'b0;
      sd           = 1'b0;
   endtask

   task automatic chan(input logic [31:0] bits, input int n, input bit with_delay);
      if (with_delay) strobe(1'b1);
      for (int i = n - 1; i >= 0; i--) strobe(bits[i]);
      cur_m = exp_word(bits, n);
   endtask

   // Drives one WS change; optional coincident strobe, ack and overrun clear.
   task automatic ws_change(input logic w, input bit with_strobe, input bit ack, input bit clr);
      pair_t p;
      logic  set_ov;
      @(negedge clk);
      ws            = w;
      ws_edge       = 1'b1;
      shift_strobe  = with_strobe;
      sd            = 1'b1;
      sample_ack    = ack;
      clear_overrun = clr;
      set_ov        = 1'b0;
      if (!active_m) begin
         if (!w) active_m = 1'b1;
      end else if (w) begin
         left_m      = cur_m;
         left_have_m = 1'b1;
      end else begin
         if (left_have_m) begin
            set_ov  = valid_m && !ack;
            p.l     = left_m;
            p.r     = cur_m;
            p.ov    = set_ov ? 1'b1 : (clr ? 1'b0 : ov_m);
            sb.push_back(p);
            valid_m = 1'b1;
            ov_m    = p.ov;
         end else if (ack) begin
            valid_m = 1'b0;
         end
         left_have_m = 1'b0;
      end
      if (left_have_m || w || !active_m) begin
         if (ack && sb.size() == 0) valid_m = 1'b0;
         if (clr && !set_ov) ov_m = 1'b0;
      end else if (clr && !set_ov) begin
         ov_m = 1'b0;
      end
      cur_m = '0;
      @(negedge clk);
      ws_edge       = 1'b0;
      shift_strobe  = 1'b0;
      sd            = 1'b0;
      sample_ack    = 1'b0;
      clear_overrun = 1'b0;
      if (sb.size() != 0) begin
         p = sb.pop_front();
         check("pair.left",  32'(left_data),  32'(p.l));
         check("pair.right", 32'(right_data), 32'(p.r));
      end
      check_status("edge");
   endtask

   task automatic pulse(input bit ack, input bit clr);
      @(negedge clk);
      sample_ack    = ack;
      clear_overrun = clr;
      if (ack) valid_m = 1'b0;
      if (clr) ov_m = 1'b0;
      @(negedge clk);
      sample_ack    = 1'b0;
      clear_overrun = 1'b0;
      check_status(ack ? "ack" : "clr");
   endtask

   task automatic frame(input logic [31:0] lb, input logic [31:0] rb, input int n,
                        input bit ldelay, input bit ack, input bit clr);
      chan(lb, n, ldelay);
      ws_change(1'b1, 1'b0, 1'b0, 1'b0);
      chan(rb, n, 1'b1);
      ws_change(1'b0, 1'b0, ack, clr);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; ws = 1'b0; ws_edge = 1'b0; shift_strobe = 1'b0;
      sd = 1'b0; sample_ack = 1'b0; clear_overrun = 1'b0;
      active_m = 1'b0; left_have_m = 1'b0; valid_m = 1'b0; ov_m = 1'b0;
      left_m = '0; cur_m = '0;
      repeat (3) @(negedge clk);
      check("rst.left",  32'(left_data),  32'h0);
      check("rst.right", 32'(right_data), 32'h0);
      check_status("rst");
      rst    = 1'b0;
      enable = 1'b1;

      // Basic 16-bit frame, then ack
      ws_change(1'b0, 1'b0, 1'b0, 1'b0);
      frame(32'hA5C3, 32'h1234, 16, 1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);

      // Short 12-bit and long 20-bit frames
      frame(32'hABC, 32'hABC, 12, 1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      frame(32'hFFFF0, 32'hFFFF0, 20, 1'b1, 1'b0, 1'b0);

      // Second pair without ack: overrun, then clear and ack
      frame(32'h1111, 32'h2222, 16, 1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);

      // Ack in the completion cycle; then overrun set coinciding with clear
      frame(32'h3333, 32'h0000, 16, 1'b1, 1'b0, 1'b0);
      frame(32'h4444, 32'h5555, 16, 1'b1, 1'b1, 1'b0);
      frame(32'h6666, 32'h7777, 16, 1'b1, 1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      pulse(1'b1, 1'b0);

      // Strobes coincident with WS edges act as the delay slot
      chan(32'hBEEF, 16, 1'b1);
      ws_change(1'b1, 1'b1, 1'b0, 1'b0);
      chan(32'hCAFE, 16, 1'b0);
      ws_change(1'b0, 1'b1, 1'b0, 1'b0);
      frame(32'h0F0F, 32'hF0F0, 16, 1'b0, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);

      // Disable after a left word, re-enable mid right word
      chan(32'h9999, 16, 1'b1);
      ws_change(1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      enable      = 1'b0;
      active_m    = 1'b0;
      left_have_m = 1'b0;
      repeat (2) @(negedge clk);
      check_status("dis");
      check("dis.left", 32'(left_data), 32'h0F0F);
      pulse(1'b1, 1'b0);
      ws     = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 3; i++) strobe(1'b1);
      ws_change(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) strobe(1'b0);
      ws_change(1'b0, 1'b0, 1'b0, 1'b0);
      frame(32'h1357, 32'h2468, 16, 1'b1, 1'b0, 1'b0);

      // Reset mid-SHIFT, outputs clear asynchronously
      strobe(1'b1);
      for (int i = 0; i < 5; i++) strobe(1'b1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      active_m = 1'b0; left_have_m = 1'b0; valid_m = 1'b0; ov_m = 1'b0;
      check("arst.left",  32'(left_data),  32'h0);
      check("arst.right", 32'(right_data), 32'h0);
      check_status("arst");
      @(negedge clk);
      rst = 1'b0;
      ws_change(1'b0, 1'b0, 1'b0, 1'b0);
      frame(32'hACE1, 32'hBD02, 16, 1'b1, 1'b0, 1'b0);

      check("sb.empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
